// File: rtl/apu_sync_sequencer.sv
// rtl/apu_sync_sequencer.sv - APU sync qualification and APU/CPU start sequencing
//
// Qualifies the asynchronous active-low APU sync, counts APU-clock falling-edge
// strobes before opening the APU clock gate, then counts CPU-clock falling-edge
// strobes before releasing CPU reset. The result is a repeatable APU/CPU start
// alignment.
//
// Ports:
//   clk         master PLL clock
//   reset       synchronous, active-low reset
//   apusync     asynchronous APU sync, active low
//   apu_fall    one-cycle strobe on the APU clock falling edge
//   cpu_fall    one-cycle strobe on the CPU clock falling edge
//   apu_gate    1 = APU clock enabled
//   cpu_hold    1 = CPU held in reset
//   start_pulse one-cycle strobe on entry to RUN
//   sync_err    sticky timeout flag
//   state       current FSM state (debug)

module apu_sync_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int APU_DELAY   = 3,
    parameter int CPU_DELAY   = 8,
    parameter int TIMEOUT     = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apusync,
    input  logic       apu_fall,
    input  logic       cpu_fall,
    output logic       apu_gate,
    output logic       cpu_hold,
    output logic       start_pulse,
    output logic       sync_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_DLY_APU   = 3'd3,
        ST_DLY_CPU   = 3'd4,
        ST_RUN       = 3'd5,
        ST_ERR       = 3'd6
    } state_t;

    localparam logic [3:0]  FLT_MAX  = 4'(FILTER_LEN);
    localparam logic [3:0]  FLT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [7:0]  APU_CNT  = 8'(APU_DELAY);
    localparam logic [7:0]  CPU_CNT  = 8'(CPU_DELAY);
    localparam logic [23:0] TO_LAST  = 24'(TIMEOUT - 1);

    // Synchroniser; flops reset to the idle-high level of apusync.
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], apusync};
        end
    end

    assign s_sync = sync_ff[SYNC_STAGES-1];

    // Low-level filter: sync_q fires once, on the cycle the count saturates.
    logic [3:0] flt_cnt;
    logic       sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            flt_cnt <= '0;
            sync_q  <= 1'b0;
        end else begin
            sync_q <= 1'b0;
            if (s_sync) begin
                flt_cnt <= '0;
            end else if (flt_cnt != FLT_MAX) begin
                flt_cnt <= flt_cnt + 4'd1;
                sync_q  <= (flt_cnt == FLT_LAST);
            end
        end
    end

    // Sequencer
    state_t      state_q;
    logic [3:0]  arm_cnt;
    logic [23:0] to_cnt;
    logic [7:0]  edge_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            arm_cnt     <= '0;
            to_cnt      <= '0;
            edge_cnt    <= '0;
            apu_gate    <= 1'b0;
            cpu_hold    <= 1'b1;
            start_pulse <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    arm_cnt <= '0;
                    to_cnt  <= '0;
                    state_q <= ST_ARM;
                end

                // Need a clean high run first so a sync already low at
                // start-up can never launch a sequence.
                ST_ARM: begin
                    if (to_cnt == TO_LAST) begin
                        sync_err <= 1'b1;
                        state_q  <= ST_ERR;
                    end else begin
                        to_cnt <= to_cnt + 24'd1;
                        if (!s_sync) begin
                            arm_cnt <= '0;
                        end else if (arm_cnt == FLT_LAST) begin
                            state_q <= ST_WAIT_SYNC;
                        end else begin
                            arm_cnt <= arm_cnt + 4'd1;
                        end
                    end
                end

                // sync_q has priority over an expiring timeout.
                ST_WAIT_SYNC: begin
                    if (sync_q) begin
                        edge_cnt <= '0;
                        if (APU_CNT == 8'd0) begin
                            apu_gate <= 1'b1;
                            state_q  <= ST_DLY_CPU;
                        end else begin
                            state_q  <= ST_DLY_APU;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        sync_err <= 1'b1;
                        state_q  <= ST_ERR;
                    end else begin
                        to_cnt <= to_cnt + 24'd1;
                    end
                end

                ST_DLY_APU: begin
                    if (apu_fall) begin
                        if (edge_cnt + 8'd1 == APU_CNT) begin
                            edge_cnt <= '0;
                            apu_gate <= 1'b1;
                            state_q  <= ST_DLY_CPU;
                        end else begin
                            edge_cnt <= edge_cnt + 8'd1;
                        end
                    end
                end

                ST_DLY_CPU: begin
                    if (CPU_CNT == 8'd0 || (cpu_fall && edge_cnt + 8'd1 == CPU_CNT)) begin
                        edge_cnt    <= '0;
                        cpu_hold    <= 1'b0;
                        start_pulse <= 1'b1;
                        state_q     <= ST_RUN;
                    end else if (cpu_fall) begin
                        edge_cnt <= edge_cnt + 8'd1;
                    end
                end

                ST_RUN: begin
                    apu_gate <= 1'b1;
                    cpu_hold <= 1'b0;
                end

                ST_ERR: begin
                    apu_gate <= 1'b0;
                    cpu_hold <= 1'b1;
                    sync_err <= 1'b1;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_apu_sync_sequencer.sv
// tb/tb_apu_sync_sequencer.sv - directed self-checking bench for apu_sync_sequencer

module tb_apu_sync_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_WAIT = 3'd2, S_DAPU = 3'd3,
                           S_DCPU = 3'd4, S_RUN = 3'd5, S_ERR  = 3'd6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, apusync_a, apu_fall_a, cpu_fall_a;
    logic       apu_gate_a, cpu_hold_a, start_pulse_a, sync_err_a;
    logic [2:0] state_a;

    logic       reset_b, apusync_b, apu_fall_b, cpu_fall_b;
    logic       apu_gate_b, cpu_hold_b, start_pulse_b, sync_err_b;
    logic [2:0] state_b;

    apu_sync_sequencer u_dut_a (
        .clk(clk), .reset(reset_a), .apusync(apusync_a),
        .apu_fall(apu_fall_a), .cpu_fall(cpu_fall_a),
        .apu_gate(apu_gate_a), .cpu_hold(cpu_hold_a),
        .start_pulse(start_pulse_a), .sync_err(sync_err_a), .state(state_a)
    );

    apu_sync_sequencer #(
        .APU_DELAY(0), .CPU_DELAY(0), .TIMEOUT(100)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .apusync(apusync_b),
        .apu_fall(apu_fall_b), .cpu_fall(cpu_fall_b),
        .apu_gate(apu_gate_b), .cpu_hold(cpu_hold_b),
        .start_pulse(start_pulse_b), .sync_err(sync_err_b), .state(state_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_a(input string tag, input logic [2:0] st, input logic gate,
                           input logic hold, input logic sp);
        check({tag, ".state"}, state_a, st);
        check({tag, ".apu_gate"}, apu_gate_a, gate);
        check({tag, ".cpu_hold"}, cpu_hold_a, hold);
        check({tag, ".start_pulse"}, start_pulse_a, sp);
    endtask

    // Reset pulse, then run ARM to completion with apusync high.
    task automatic arm_a(input string tag);
        apusync_a = 1'b1;
        reset_a = 1'b0;
        tick(1);
        reset_a = 1'b1;
        tick(5);
        check({tag, ".armed"}, state_a, S_WAIT);
    endtask

    // From WAIT_SYNC: drive sync low and walk through both delay phases.
    // With coinc set, an apu_fall lands on the sync_q cycle and a cpu_fall
    // on the apu_gate-asserting cycle; neither may be counted.
    task automatic full_seq_a(input string tag, input bit coinc);
        apusync_a = 1'b0;
        tick(6);
        check({tag, ".presync"}, state_a, S_WAIT);
        apu_fall_a = coinc;
        tick(1);
        apu_fall_a = 1'b0;
        check({tag, ".dly_apu"}, state_a, S_DAPU);
        apusync_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            apu_fall_a = 1'b1;
            cpu_fall_a = coinc && (i == 3);
            tick(1);
            apu_fall_a = 1'b0;
            cpu_fall_a = 1'b0;
            check({tag, ".apu_gate"}, apu_gate_a, (i == 3));
            check({tag, ".apu_state"}, state_a, (i == 3) ? S_DCPU : S_DAPU);
            tick(2);
        end
        for (int i = 1; i <= 8; i++) begin
            cpu_fall_a = 1'b1;
            tick(1);
            cpu_fall_a = 1'b0;
            check({tag, ".cpu_hold"}, cpu_hold_a, (i != 8));
            check({tag, ".start"}, start_pulse_a, (i == 8));
            tick(1);
            check({tag, ".start_drop"}, start_pulse_a, 1'b0);
            tick(1);
        end
        check_a({tag, ".run"}, S_RUN, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_a = 1'b0; apusync_a = 1'b1; apu_fall_a = 1'b0; cpu_fall_a = 1'b0;
        reset_b = 1'b0; apusync_b = 1'b1; apu_fall_b = 1'b0; cpu_fall_b = 1'b0;
        tick(2);
        check_a("reset", S_IDLE, 1'b0, 1'b1, 1'b0);
        check("reset.sync_err", sync_err_a, 1'b0);

        // Main sequence with coincident strobes
        reset_a = 1'b1;
        tick(1);
        check("main.arm", state_a, S_ARM);
        tick(3);
        check("main.arm_hold", state_a, S_ARM);
        tick(1);
        check("main.wait", state_a, S_WAIT);
        tick(5);
        full_seq_a("main", 1'b1);
        for (int i = 0; i < 6; i++) begin
            apusync_a = i[0]; apu_fall_a = 1'b1; cpu_fall_a = 1'b1;
            tick(1);
        end
        apusync_a = 1'b1; apu_fall_a = 1'b0; cpu_fall_a = 1'b0;
        tick(1);
        check_a("run_hold", S_RUN, 1'b1, 1'b0, 1'b0);

        // Glitch shorter than the filter is ignored
        arm_a("glitch");
        apusync_a = 1'b0;
        tick(3);
        apusync_a = 1'b1;
        tick(10);
        check("glitch.state", state_a, S_WAIT);
        check("glitch.apu_gate", apu_gate_a, 1'b0);
        full_seq_a("after_glitch", 1'b0);

        // Reset during DLY_CPU with a partial cpu count
        arm_a("midrst");
        apusync_a = 1'b0;
        tick(7);
        apusync_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apu_fall_a = 1'b1; tick(1); apu_fall_a = 1'b0; tick(1);
        end
        check("midrst.dly_cpu", state_a, S_DCPU);
        for (int i = 0; i < 3; i++) begin
            cpu_fall_a = 1'b1; tick(1); cpu_fall_a = 1'b0; tick(1);
        end
        reset_a = 1'b0;
        tick(1);
        check_a("midrst.cleared", S_IDLE, 1'b0, 1'b1, 1'b0);
        reset_a = 1'b1;
        tick(5);
        check("midrst.rearm", state_a, S_WAIT);
        full_seq_a("reseq", 1'b0);

        // apusync already low at reset release
        reset_a = 1'b0; apusync_a = 1'b0;
        tick(2);
        reset_a = 1'b1;
        tick(1);
        check("initlow.arm", state_a, S_ARM);
        tick(14);
        check("initlow.hold", state_a, S_ARM);
        apusync_a = 1'b1;
        tick(5);
        check("initlow.still_arm", state_a, S_ARM);
        tick(1);
        check("initlow.wait", state_a, S_WAIT);
        tick(10);
        check("initlow.no_start", state_a, S_WAIT);
        check("initlow.apu_gate", apu_gate_a, 1'b0);

        // Zero delays: gate one cycle after sync_q, release one cycle later
        reset_b = 1'b1;
        tick(10);
        check("zero.wait", state_b, S_WAIT);
        apusync_b = 1'b0;
        tick(6);
        check("zero.pre_gate", apu_gate_b, 1'b0);
        tick(1);
        check("zero.gate", apu_gate_b, 1'b1);
        check("zero.dly_cpu", state_b, S_DCPU);
        check("zero.hold", cpu_hold_b, 1'b1);
        tick(1);
        check("zero.release", cpu_hold_b, 1'b0);
        check("zero.start", start_pulse_b, 1'b1);
        check("zero.run", state_b, S_RUN);
        tick(1);
        check("zero.start_drop", start_pulse_b, 1'b0);

        // Timeout with apusync held high
        apusync_b = 1'b1;
        reset_b = 1'b0;
        tick(1);
        check("to.reset_state", state_b, S_IDLE);
        check("to.reset_gate", apu_gate_b, 1'b0);
        reset_b = 1'b1;
        tick(100);
        check("to.before", state_b, S_WAIT);
        check("to.before_err", sync_err_b, 1'b0);
        tick(1);
        check("to.err_state", state_b, S_ERR);
        check("to.sync_err", sync_err_b, 1'b1);
        check("to.gate", apu_gate_b, 1'b0);
        check("to.hold", cpu_hold_b, 1'b1);
        for (int i = 0; i < 20; i++) begin
            apusync_b = i[0]; apu_fall_b = 1'b1; cpu_fall_b = i[1];
            tick(1);
        end
        apusync_b = 1'b1; apu_fall_b = 1'b0; cpu_fall_b = 1'b0;
        check("to.sticky_state", state_b, S_ERR);
        check("to.sticky_err", sync_err_b, 1'b1);
        reset_b = 1'b0;
        tick(1);
        check("to.clear_err", sync_err_b, 1'b0);
        check("to.clear_state", state_b, S_IDLE);
        reset_b = 1'b1;
        tick(1);
        check("to.rearm", state_b, S_ARM);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
